// File: rtl/hazard_flush_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_flush_ctrl
//   Pipeline sequencer for the 5-stage ARM core. Produces the freeze/flush
//   controls for the PC, the IF/ID and ID/EX stage registers, detects RAW
//   hazards against EXE/MEM destinations, flushes on taken branches and
//   freezes the whole pipe while a multi-cycle SRAM access is outstanding.
//   A stuck SRAM access ends in a sticky error state.
//
//   Build option: define FORWARDING_EN to enable the EXE-stage forwarding
//   selects. With forwarding only load-use hazards stall the pipe.
//
// Parameters
//   MEM_TIMEOUT  frozen cycles allowed per SRAM access before mem_err (>=2)
//   CNT_W        width of the saturating stall/flush counters
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   src1_id/src2_id              source register indices of the ID instruction
//   use_src1_id/two_src_id       ID instruction reads src1 / src2
//   exe_wb_en/exe_dest           EXE write-back enable / destination
//   exe_mem_r_en                 EXE instruction is a load
//   mem_wb_en/mem_dest           MEM write-back enable / destination
//   wb_wb_en/wb_dest             WB write-back enable / destination
//   src1_exe/src2_exe            source indices of the EXE instruction
//   branch_taken                 branch resolved taken in EXE
//   mem_req/mem_ready            SRAM request / SRAM done this cycle
//   freeze_pc                    hold PC and IF/ID
//   flush_if_id/flush_id_ex      clear IF/ID / bubble into ID/EX
//   freeze_all                   hold every stage register and the PC
//   fwd_sel1/fwd_sel2            ALU operand source: 00 reg, 01 MEM, 10 WB
//   mem_err                      sticky SRAM timeout flag
//   stall_cnt/flush_cnt          saturating event counters
// ---------------------------------------------------------------------------
// state    | meaning
// S_RUN    | pipe advancing, no SRAM access outstanding
// S_MEMWT  | SRAM access outstanding, pipe frozen until mem_ready
// S_ERR    | SRAM timed out, pipe frozen until reset
// ---------------------------------------------------------------------------
module hazard_flush_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src1_id,
  input  logic [3:0]       src2_id,
  input  logic             use_src1_id,
  input  logic             two_src_id,
  input  logic             exe_wb_en,
  input  logic [3:0]       exe_dest,
  input  logic             exe_mem_r_en,
  input  logic             mem_wb_en,
  input  logic [3:0]       mem_dest,
  input  logic             wb_wb_en,
  input  logic [3:0]       wb_dest,
  input  logic [3:0]       src1_exe,
  input  logic [3:0]       src2_exe,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             freeze_all,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_MEMWT = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              mem_err_d;
  logic              frz_mem;
  logic              raw_exe;
  logic              hazard;
  logic [1:0]        fwd1_raw, fwd2_raw;

  assign raw_exe = (use_src1_id && exe_wb_en && (src1_id == exe_dest)) ||
                   (two_src_id  && exe_wb_en && (src2_id == exe_dest));

`ifdef FORWARDING_EN
  // Forwarding covers everything except a load whose data is not yet back.
  assign hazard = raw_exe && exe_mem_r_en;

  always_comb begin
    fwd1_raw = 2'b00;
    if (mem_wb_en && (src1_exe == mem_dest))     fwd1_raw = 2'b01;
    else if (wb_wb_en && (src1_exe == wb_dest))  fwd1_raw = 2'b10;
  end

  always_comb begin
    fwd2_raw = 2'b00;
    if (mem_wb_en && (src2_exe == mem_dest))     fwd2_raw = 2'b01;
    else if (wb_wb_en && (src2_exe == wb_dest))  fwd2_raw = 2'b10;
  end
`else
  logic raw_mem;
  logic unused_fwd_inputs;

  assign raw_mem = (use_src1_id && mem_wb_en && (src1_id == mem_dest)) ||
                   (two_src_id  && mem_wb_en && (src2_id == mem_dest));
  assign hazard  = raw_exe || raw_mem;

  assign fwd1_raw = 2'b00;
  assign fwd2_raw = 2'b00;

  assign unused_fwd_inputs = ^{src1_exe, src2_exe, wb_wb_en, wb_dest, exe_mem_r_en};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      wcnt_q  <= '0;
      mem_err <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      mem_err <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_err_d = mem_err;
    frz_mem   = 1'b0;
    case (state_q)
      S_RUN: begin
        if (mem_req && !mem_ready) begin
          frz_mem = 1'b1;
          state_d = S_MEMWT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      S_MEMWT: begin
        // The mem_ready cycle is left unfrozen so the pipe advances on it.
        if (mem_ready) begin
          state_d = S_RUN;
          wcnt_d  = '0;
        end else begin
          frz_mem = 1'b1;
          if (wcnt_q == WCNT_W'(MEM_TIMEOUT - 1)) begin
            state_d   = S_ERR;
            mem_err_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end
      S_ERR: begin
        frz_mem = 1'b1;
      end
      default: begin
        state_d = S_RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  // Outputs are forced low while reset is held, independent of the inputs.
  // A frozen pipe suppresses flush/freeze_pc so a branch or hazard is seen
  // again once the stall ends.
  always_comb begin
    freeze_all  = frz_mem && !rst;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    freeze_pc   = 1'b0;
    if (!rst && !frz_mem) begin
      flush_if_id = branch_taken;
      flush_id_ex = branch_taken || hazard;
      freeze_pc   = hazard && !branch_taken;
    end
    fwd_sel1 = rst ? 2'b00 : fwd1_raw;
    fwd_sel2 = rst ? 2'b00 : fwd2_raw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((freeze_pc || freeze_all) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_if_id && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
module tb_hazard_flush_ctrl;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] src1_id, src2_id, exe_dest, mem_dest, wb_dest, src1_exe, src2_exe;
  logic use_src1_id, two_src_id, exe_wb_en, exe_mem_r_en, mem_wb_en, wb_wb_en;
  logic branch_taken, mem_req, mem_ready;
  logic freeze_pc, flush_if_id, flush_id_ex, freeze_all, mem_err;
  logic [1:0] fwd_sel1, fwd_sel2;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_flush_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .src1_id(src1_id), .src2_id(src2_id),
    .use_src1_id(use_src1_id), .two_src_id(two_src_id),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_r_en(exe_mem_r_en),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .wb_wb_en(wb_wb_en), .wb_dest(wb_dest),
    .src1_exe(src1_exe), .src2_exe(src2_exe),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_pc(freeze_pc), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .freeze_all(freeze_all), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic       freeze_pc;
    logic       flush_if_id;
    logic       flush_id_ex;
    logic       freeze_all;
    logic [1:0] fwd1;
    logic [1:0] fwd2;
    logic       mem_err;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: counts consecutive memory-frozen cycles; an access
  // outstanding is simply a nonzero run length.
  int   m_stall, m_flush, m_run;
  bit   m_err;
  exp_t last_exp;

  function automatic logic [1:0] fwd_of(input logic [3:0] s);
    logic [1:0] r = 2'b00;
`ifdef FORWARDING_EN
    if (mem_wb_en && s == mem_dest)     r = 2'b01;
    else if (wb_wb_en && s == wb_dest)  r = 2'b10;
`endif
    return r;
  endfunction

  function automatic exp_t model_out();
    exp_t e = '0;
    bit r_exe, r_mem, haz, frz;
    r_exe = exe_wb_en && ((use_src1_id && src1_id == exe_dest) || (two_src_id && src2_id == exe_dest));
    r_mem = mem_wb_en && ((use_src1_id && src1_id == mem_dest) || (two_src_id && src2_id == mem_dest));
`ifdef FORWARDING_EN
    haz = r_exe && exe_mem_r_en;
`else
    haz = r_exe || r_mem;
`endif
    frz = m_err || (!mem_ready && (m_run > 0 || mem_req));
    e.mem_err = m_err;
    e.stall   = CNT_W'(m_stall);
    e.flush   = CNT_W'(m_flush);
    if (rst) return e;
    e.freeze_all = frz;
    if (!frz) begin
      e.flush_if_id = branch_taken;
      e.flush_id_ex = branch_taken || haz;
      e.freeze_pc   = haz && !branch_taken;
    end
    e.fwd1 = fwd_of(src1_exe);
    e.fwd2 = fwd_of(src2_exe);
    return e;
  endfunction

  task automatic model_reset();
    m_stall = 0; m_flush = 0; m_run = 0; m_err = 0;
    last_exp = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    if (!rst) begin
      if ((last_exp.freeze_pc || last_exp.freeze_all) && m_stall < CNT_MAX) m_stall++;
      if (last_exp.flush_if_id && m_flush < CNT_MAX) m_flush++;
      if (!m_err) begin
        if (last_exp.freeze_all) begin
          m_run++;
          if (m_run == MEM_TIMEOUT) m_err = 1;
        end else begin
          m_run = 0;
        end
      end
    end
    #1;
  endtask

  task automatic push_exp(input string tag);
    if (rst) model_reset();
    last_exp = model_out();
    exp_q.push_back(last_exp);
    tag_q.push_back(tag);
  endtask

  task automatic clear_inputs();
    src1_id = 0; src2_id = 0; use_src1_id = 0; two_src_id = 0;
    exe_wb_en = 0; exe_dest = 0; exe_mem_r_en = 0;
    mem_wb_en = 0; mem_dest = 0; wb_wb_en = 0; wb_dest = 0;
    src1_exe = 0; src2_exe = 0; branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t  e;
        exp_t  a;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = '{freeze_pc, flush_if_id, flush_id_ex, freeze_all, fwd_sel1, fwd_sel2,
              mem_err, stall_cnt, flush_cnt};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s t=%0t got fpc/fif/fex/fall=%b%b%b%b fwd=%b/%b err=%b st=%0d fl=%0d want %b%b%b%b fwd=%b/%b err=%b st=%0d fl=%0d",
                   t, $time, a.freeze_pc, a.flush_if_id, a.flush_id_ex, a.freeze_all, a.fwd1, a.fwd2,
                   a.mem_err, a.stall, a.flush, e.freeze_pc, e.flush_if_id, e.flush_id_ex, e.freeze_all,
                   e.fwd1, e.fwd2, e.mem_err, e.stall, e.flush);
        end
      end
    end
  end

  initial begin
    model_reset();
    rst = 1'b1;
    clear_inputs();
    mem_req = 1; // outputs must stay low under reset regardless of inputs
    branch_taken = 1;
    next_cycle(); push_exp("reset");
    next_cycle(); clear_inputs(); rst = 1'b0; push_exp("release");

    // RAW hazard on EXE destination
    next_cycle(); src1_id = 3; use_src1_id = 1; exe_dest = 3; exe_wb_en = 1; push_exp("raw_exe");
    next_cycle(); clear_inputs(); push_exp("stall_cnt1");
    // same with branch: branch wins
    next_cycle(); src1_id = 3; use_src1_id = 1; exe_dest = 3; exe_wb_en = 1; branch_taken = 1;
    push_exp("branch_hazard");
    next_cycle(); clear_inputs(); push_exp("flush_cnt1");
    // RAW on MEM destination via src2
    next_cycle(); src2_id = 7; two_src_id = 1; mem_dest = 7; mem_wb_en = 1; push_exp("raw_mem");

    // 4-cycle SRAM wait, ready on the fifth
    for (int i = 0; i < 5; i++) begin
      next_cycle(); clear_inputs(); mem_req = 1; mem_ready = (i == 4);
      branch_taken = 1; push_exp("mem_wait");
    end
    next_cycle(); clear_inputs(); branch_taken = 1; push_exp("after_wait");

    // SRAM stuck: timeout, then reset clears it
    for (int i = 0; i < MEM_TIMEOUT + 4; i++) begin
      next_cycle(); clear_inputs(); mem_req = 1; push_exp("timeout");
    end
    next_cycle(); rst = 1; push_exp("err_reset");
    next_cycle(); rst = 0; clear_inputs(); push_exp("err_cleared");

    // reset asserted mid MEM_WAIT
    for (int i = 0; i < 3; i++) begin
      next_cycle(); clear_inputs(); mem_req = 1; push_exp("pre_rst_wait");
    end
    next_cycle(); rst = 1; push_exp("rst_mid_wait");
    next_cycle(); rst = 0; clear_inputs(); src1_id = 3; use_src1_id = 1; exe_dest = 3; exe_wb_en = 1;
    push_exp("run_after_rst");

`ifdef FORWARDING_EN
    next_cycle(); clear_inputs(); src1_exe = 5; mem_dest = 5; wb_dest = 5; mem_wb_en = 1; wb_wb_en = 1;
    src2_exe = 5; push_exp("fwd_mem_prio");
    next_cycle(); clear_inputs(); exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 2; src2_id = 2; two_src_id = 1;
    push_exp("load_use");
    next_cycle(); clear_inputs(); mem_wb_en = 1; mem_dest = 2; src2_id = 2; two_src_id = 1; src2_exe = 2;
    push_exp("load_use_done");
`endif

    // randomized traffic, with occasional stuck SRAM and resets
    for (int i = 0; i < 600; i++) begin
      next_cycle();
      rst          = ($urandom_range(0, 149) == 0);
      src1_id      = 4'($urandom_range(0, 3));
      src2_id      = 4'($urandom_range(0, 3));
      use_src1_id  = 1'($urandom_range(0, 1));
      two_src_id   = 1'($urandom_range(0, 1));
      exe_wb_en    = 1'($urandom_range(0, 1));
      exe_dest     = 4'($urandom_range(0, 3));
      exe_mem_r_en = 1'($urandom_range(0, 1));
      mem_wb_en    = 1'($urandom_range(0, 1));
      mem_dest     = 4'($urandom_range(0, 3));
      wb_wb_en     = 1'($urandom_range(0, 1));
      wb_dest      = 4'($urandom_range(0, 3));
      src1_exe     = 4'($urandom_range(0, 3));
      src2_exe     = 4'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 3) == 0);
      mem_req      = ($urandom_range(0, 3) == 0);
      mem_ready    = ((i % 200) > 170) ? 1'b0 : ($urandom_range(0, 2) == 0);
      push_exp("random");
    end

    next_cycle(); clear_inputs(); push_exp("final");
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
